// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port round-robin arbiter in front of a single-ported synchronous data
// memory. The CPU data port and the host/test-loader port share one memory;
// at most one of them is granted per cycle, and the grant is combinational so
// consecutive grants need no idle cycle between them.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_req/addr/wdata/wen        CPU request (wen == 0 means read)
//   cpu_gnt/rvalid/rdata          CPU grant and read return
//   host_*                        same set for the host port
//   mem_en/addr/wdata/wen         memory strobe, word index, data, byte enables
//   mem_rdata                     memory read data, one cycle after a read
//   cpu_wait_cnt, host_wait_cnt   saturating counts of held-but-not-granted
//                                 cycles per port
//   addr_err                      pulse on a granted out-of-range access
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_SIZE_WORDS = 1024,
  parameter int WAIT_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wen,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,

  input  logic                  host_req,
  input  logic [31:0]           host_addr,
  input  logic [31:0]           host_wdata,
  input  logic [3:0]            host_wen,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,

  output logic                  mem_en,
  output logic [29:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wen,
  input  logic [31:0]           mem_rdata,

  output logic [WAIT_CNT_W-1:0] cpu_wait_cnt,
  output logic [WAIT_CNT_W-1:0] host_wait_cnt,
  output logic                  addr_err
);

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

  // Byte-address limit, one bit wider than the address so the full 32-bit
  // address (including the byte offset bits) takes part in the range check.
  localparam logic [32:0]           ADDR_LIMIT = 33'(MEM_SIZE_WORDS) * 33'd4;
  localparam logic [31:0]           ERR_RDATA  = 32'hDEADBEEF;
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE    = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  port_e                 last_q, last_d;
  logic                  rd_vld_q, rd_vld_d;
  port_e                 rd_own_q, rd_own_d;
  logic                  rd_err_q, rd_err_d;
  logic [WAIT_CNT_W-1:0] cpu_wait_q, cpu_wait_d;
  logic [WAIT_CNT_W-1:0] host_wait_q, host_wait_d;

  logic        any_gnt;
  logic        in_range;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wen;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(
    input logic [WAIT_CNT_W-1:0] val,
    input logic                  en
  );
    if (en && (val != CNT_MAX)) begin
      return val + CNT_ONE;
    end
    return val;
  endfunction

  // Arbitration and memory-side drive
  always_comb begin
    // rst_n gates the grants so the whole request path drops at once when
    // reset is asserted, without waiting for a clock edge.
    cpu_gnt  = rst_n & cpu_req  & (~host_req | (last_q == PORT_HOST));
    host_gnt = rst_n & host_req & (~cpu_req  | (last_q == PORT_CPU));
    any_gnt  = cpu_gnt | host_gnt;

    sel_addr  = host_gnt ? host_addr  : cpu_addr;
    sel_wdata = host_gnt ? host_wdata : cpu_wdata;
    sel_wen   = host_gnt ? host_wen   : cpu_wen;

    in_range = ({1'b0, sel_addr} < ADDR_LIMIT);

    mem_en    = any_gnt & in_range;
    mem_addr  = mem_en ? sel_addr[31:2] : 30'd0;
    mem_wdata = mem_en ? sel_wdata      : 32'd0;
    mem_wen   = mem_en ? sel_wen        : 4'd0;
    addr_err  = any_gnt & ~in_range;

    last_d = last_q;
    if (cpu_gnt) begin
      last_d = PORT_CPU;
    end else if (host_gnt) begin
      last_d = PORT_HOST;
    end

    // A granted read (in range or not) returns data on the next cycle; the
    // owner and the error flag travel with it so the return is routed and
    // substituted correctly even when reads are back to back.
    rd_vld_d = any_gnt & (sel_wen == 4'd0);
    rd_own_d = host_gnt ? PORT_HOST : PORT_CPU;
    rd_err_d = ~in_range;

    cpu_wait_d  = sat_inc(cpu_wait_q,  cpu_req  & ~cpu_gnt);
    host_wait_d = sat_inc(host_wait_q, host_req & ~host_gnt);
  end

  // Registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= PORT_HOST;
      rd_vld_q    <= 1'b0;
      rd_own_q    <= PORT_CPU;
      rd_err_q    <= 1'b0;
      cpu_wait_q  <= '0;
      host_wait_q <= '0;
    end else begin
      last_q      <= last_d;
      rd_vld_q    <= rd_vld_d;
      rd_own_q    <= rd_own_d;
      rd_err_q    <= rd_err_d;
      cpu_wait_q  <= cpu_wait_d;
      host_wait_q <= host_wait_d;
    end
  end

  // Read return, one cycle after the grant
  always_comb begin
    cpu_rvalid  = rd_vld_q & (rd_own_q == PORT_CPU);
    host_rvalid = rd_vld_q & (rd_own_q == PORT_HOST);
    cpu_rdata   = 32'd0;
    host_rdata  = 32'd0;
    if (cpu_rvalid) begin
      cpu_rdata = rd_err_q ? ERR_RDATA : mem_rdata;
    end
    if (host_rvalid) begin
      host_rdata = rd_err_q ? ERR_RDATA : mem_rdata;
    end
    cpu_wait_cnt  = cpu_wait_q;
    host_wait_cnt = host_wait_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (round-robin rule, word-array memory image, one-deep read return, saturating
// wait counts) predicts every output each cycle. A small RAM model is attached
// to the memory port. The wait counters are built 8 bits wide here so that
// saturation is reached in a few hundred cycles of contention.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int          MEM_WORDS = 1024;
  localparam int          WCW       = 8;
  localparam int          WMAX      = (1 << WCW) - 1;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } op_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cpu_req, host_req;
  logic [31:0]    cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [3:0]     cpu_wen, host_wen;
  logic           cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0]    cpu_rdata, host_rdata;
  logic           mem_en;
  logic [29:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wen;
  logic [31:0]    mem_rdata;
  logic [WCW-1:0] cpu_wait_cnt, host_wait_cnt;
  logic           addr_err;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_SIZE_WORDS(MEM_WORDS), .WAIT_CNT_W(WCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_wen(host_wen),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata),
    .cpu_wait_cnt(cpu_wait_cnt), .host_wait_cnt(host_wait_cnt), .addr_err(addr_err)
  );

  // Synchronous RAM on the memory port; returns junk when not reading so
  // that ungated read data would be visible.
  logic [31:0] ram [0:MEM_WORDS-1];
  logic        ram_clr;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_en && mem_wen == 4'd0) mem_rdata <= ram[mem_addr[9:0]];
      else                           mem_rdata <= $urandom;
      if (mem_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  int          last_win;        // 0 = CPU won last, 1 = host won last
  logic        exp_cpu_rv, exp_host_rv;
  logic [31:0] exp_rd;
  int          cpu_w, host_w;

  int          checks = 0;
  int          errors = 0;
  logic        g_cpu, g_host;
  logic        obs_addr_err, obs_mem_en, obs_cpu_rvalid, obs_host_rvalid;
  logic [31:0] obs_cpu_rdata;
  int          en_count;
  op_t         cpu_q[$];
  op_t         host_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cgnt"}, 32'(cpu_gnt), 0);
    chk({tag, "_hgnt"}, 32'(host_gnt), 0);
    chk({tag, "_men"},  32'(mem_en), 0);
    chk({tag, "_mwen"}, 32'(mem_wen), 0);
    chk({tag, "_aerr"}, 32'(addr_err), 0);
    chk({tag, "_crv"},  32'(cpu_rvalid), 0);
    chk({tag, "_hrv"},  32'(host_rvalid), 0);
    chk({tag, "_crd"},  cpu_rdata, 0);
    chk({tag, "_hrd"},  host_rdata, 0);
    chk({tag, "_cw"},   32'(cpu_wait_cnt), 0);
    chk({tag, "_hw"},   32'(host_wait_cnt), 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return $urandom | 32'h0000_1000;             // out of range
    if (r == 1) return 32'h0000_0FFC + 32'($urandom_range(0, 7)); // around the top edge
    return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // Entered at posedge+1: checks the cycle's outputs at the falling edge,
  // then advances the model across the next rising edge.
  task automatic do_cycle();
    logic ec, eh, gr, inr;
    logic [31:0] a, wd;
    logic [3:0]  we;
    ec  = cpu_req  && (!host_req || last_win == 1);
    eh  = host_req && (!cpu_req  || last_win == 0);
    gr  = ec || eh;
    a   = eh ? host_addr  : cpu_addr;
    wd  = eh ? host_wdata : cpu_wdata;
    we  = eh ? host_wen   : cpu_wen;
    inr = (a < MEM_BYTES);
    @(negedge clk);
    chk("cpu_gnt",  32'(cpu_gnt),  32'(ec));
    chk("host_gnt", 32'(host_gnt), 32'(eh));
    chk("mem_en",   32'(mem_en),   32'(gr && inr));
    chk("mem_wen",  32'(mem_wen),  (gr && inr) ? 32'(we) : 32'd0);
    if (gr && inr) begin
      chk("mem_addr",  {2'b00, mem_addr}, {2'b00, a[31:2]});
      chk("mem_wdata", mem_wdata, wd);
    end
    chk("addr_err",    32'(addr_err),    32'(gr && !inr));
    chk("cpu_rvalid",  32'(cpu_rvalid),  32'(exp_cpu_rv));
    chk("cpu_rdata",   cpu_rdata,  exp_cpu_rv  ? exp_rd : 32'd0);
    chk("host_rvalid", 32'(host_rvalid), 32'(exp_host_rv));
    chk("host_rdata",  host_rdata, exp_host_rv ? exp_rd : 32'd0);
    chk("cpu_wait",    32'(cpu_wait_cnt),  32'(cpu_w));
    chk("host_wait",   32'(host_wait_cnt), 32'(host_w));
    obs_addr_err    = addr_err;
    obs_mem_en      = mem_en;
    obs_cpu_rvalid  = cpu_rvalid;
    obs_host_rvalid = host_rvalid;
    obs_cpu_rdata   = cpu_rdata;
    if (mem_en) en_count++;
    g_cpu  = ec;
    g_host = eh;
    @(posedge clk);
    exp_cpu_rv  = ec && (we == 4'd0);
    exp_host_rv = eh && (we == 4'd0);
    exp_rd      = inr ? ref_mem[a[11:2]] : 32'hDEADBEEF;
    if (gr && inr && we != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    end
    if (ec) last_win = 0;
    else if (eh) last_win = 1;
    if (cpu_req  && !ec && cpu_w  < WMAX) cpu_w++;
    if (host_req && !eh && host_w < WMAX) host_w++;
    #1;
  endtask

  // Presents the head of each port's queue, holding it until granted.
  task automatic run_queues(input int budget);
    int n = 0;
    while ((cpu_q.size() > 0 || host_q.size() > 0) && n < budget) begin
      cpu_req  = (cpu_q.size() > 0);
      host_req = (host_q.size() > 0);
      if (cpu_req)  begin cpu_addr  = cpu_q[0].addr;  cpu_wdata  = cpu_q[0].wdata;  cpu_wen  = cpu_q[0].wen;  end
      if (host_req) begin host_addr = host_q[0].addr; host_wdata = host_q[0].wdata; host_wen = host_q[0].wen; end
      do_cycle();
      if (g_cpu)  void'(cpu_q.pop_front());
      if (g_host) void'(host_q.pop_front());
      n++;
    end
    cpu_req  = 1'b0;
    host_req = 1'b0;
    chk("queue_drain", 32'(cpu_q.size() + host_q.size()), 0);
    cpu_q.delete();
    host_q.delete();
  endtask

  // Entered at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic apply_reset();
    rst_n      = 1'b0;
    last_win   = 1;
    exp_cpu_rv = 1'b0;
    exp_host_rv = 1'b0;
    cpu_w      = 0;
    host_w     = 0;
    cpu_req    = 1'b1;
    host_req   = 1'b1;
    cpu_addr   = 32'h40;  cpu_wen  = 4'd0;
    host_addr  = 32'h80;  host_wen = 4'hF;
    #1;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    cpu_req  = 1'b0;
    host_req = 1'b0;
    rst_n    = 1'b1;
  endtask

  logic [31:0] vals [10];
  logic [7:0]  gseq;

  initial begin
    vals = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 32'd8, 32'd2, 32'd6, 32'd4, 32'd10};
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    cpu_req = 0; host_req = 0;
    cpu_addr = 0; cpu_wdata = 0; cpu_wen = 0;
    host_addr = 0; host_wdata = 0; host_wen = 0;
    en_count = 0;
    ram_clr = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    ram_clr = 1'b0;

    // Continuous contention right after reset: CPU first, then alternating.
    for (int i = 0; i < 8; i++) begin
      cpu_req  = 1'b1; cpu_addr  = 32'($urandom_range(0, 255)) << 2; cpu_wen  = 4'd0;
      host_req = 1'b1; host_addr = 32'($urandom_range(0, 255)) << 2; host_wen = 4'd0;
      do_cycle();
      gseq[i] = g_cpu;
    end
    chk("rr_sequence", 32'(gseq), 32'h55);
    chk("rr_cpu_wait", 32'(cpu_wait_cnt), 4);
    chk("rr_host_wait", 32'(host_wait_cnt), 4);
    cpu_req = 0; host_req = 0;
    do_cycle();

    // Host loads ten words, CPU reads them back.
    for (int i = 0; i < 10; i++)
      host_q.push_back('{addr: 32'h200 + 32'(4 * i), wdata: vals[i], wen: 4'hF});
    run_queues(20);
    for (int i = 0; i < 10; i++) begin
      cpu_q.push_back('{addr: 32'h200 + 32'(4 * i), wdata: 32'd0, wen: 4'd0});
      run_queues(3);
      do_cycle();
      chk("load_rvalid", 32'(obs_cpu_rvalid), 1);
      chk("load_rdata", obs_cpu_rdata, vals[i]);
      chk("load_host_rv", 32'(obs_host_rvalid), 0);
    end

    // Mixed read/write traffic on consecutive cycles.
    en_count = 0;
    cpu_q.push_back('{addr: 32'h300, wdata: 32'd0, wen: 4'd0});
    host_q.push_back('{addr: 32'h304, wdata: 32'hA5A5_0304, wen: 4'hF});
    host_q.push_back('{addr: 32'h300, wdata: 32'd0, wen: 4'd0});
    run_queues(6);
    chk("mixed_en_cycles", 32'(en_count), 3);
    do_cycle();
    chk("mixed_last_host_rv", 32'(obs_host_rvalid), 1);

    // Out-of-range CPU read.
    cpu_req = 1'b1; cpu_addr = 32'h1000; cpu_wen = 4'd0;
    do_cycle();
    chk("oor_addr_err", 32'(obs_addr_err), 1);
    chk("oor_mem_en", 32'(obs_mem_en), 0);
    cpu_req = 1'b0;
    do_cycle();
    chk("oor_rvalid", 32'(obs_cpu_rvalid), 1);
    chk("oor_rdata", obs_cpu_rdata, 32'hDEADBEEF);
    chk("oor_err_once", 32'(obs_addr_err), 0);

    // Randomized traffic; requests may change or drop before being granted.
    for (int i = 0; i < 400; i++) begin
      cpu_req    = ($urandom_range(0, 3) != 0);
      cpu_addr   = rand_addr();
      cpu_wdata  = $urandom;
      cpu_wen    = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom);
      host_req   = ($urandom_range(0, 2) != 0);
      host_addr  = rand_addr();
      host_wdata = $urandom;
      host_wen   = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom);
      do_cycle();
    end

    // Long contention drives both wait counters into saturation.
    for (int i = 0; i < 600; i++) begin
      cpu_req  = 1'b1; cpu_addr  = 32'($urandom_range(0, 1023)) << 2; cpu_wen  = 4'd0;
      host_req = 1'b1; host_addr = 32'($urandom_range(0, 1023)) << 2; host_wen = 4'd0;
      do_cycle();
    end
    chk("sat_host_wait", 32'(host_wait_cnt), 32'(WMAX));
    chk("sat_cpu_wait", 32'(cpu_wait_cnt), 32'(WMAX));
    cpu_req = 0; host_req = 0;
    do_cycle();

    // Reset in the cycle right after a CPU read grant.
    cpu_req = 1'b1; cpu_addr = 32'h44; cpu_wen = 4'd0;
    do_cycle();
    chk("rst_pre_grant", 32'(g_cpu), 1);
    apply_reset();
    for (int i = 0; i < 3; i++) do_cycle();
    chk("rst_post_rv", 32'(obs_cpu_rvalid), 0);
    cpu_req = 1'b1; host_req = 1'b1;
    cpu_addr = 32'h10; host_addr = 32'h14; cpu_wen = 4'd0; host_wen = 4'd0;
    do_cycle();
    chk("rst_first_cpu", 32'(g_cpu), 1);
    cpu_req = 0; host_req = 0;
    do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
